// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions.
// Field layouts of the dispatch word (instruction_in) and the CDB word
// (solution), their widths, the ALU opcode set and the bit that marks a
// memory operation. The reservation station and memory unit import the same
// package, so every producer and consumer agrees on the encodings.
package cdb_pkg;

  localparam int TAG_W  = 3;
  localparam int REG_W  = 4;
  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;

  localparam int INSTR_W = TAG_W + OPC_W + REG_W + 2 * DATA_W;  // 43
  localparam int SOL_W   = REG_W + TAG_W + DATA_W;              // 23

  // instruction_in field bounds
  localparam int INSTR_TAG_HI  = 42;
  localparam int INSTR_TAG_LO  = 40;
  localparam int INSTR_OP_HI   = 39;
  localparam int INSTR_OP_LO   = 36;
  localparam int INSTR_DEST_HI = 35;
  localparam int INSTR_DEST_LO = 32;
  localparam int INSTR_B_HI    = 31;
  localparam int INSTR_B_LO    = 16;
  localparam int INSTR_C_HI    = 15;
  localparam int INSTR_C_LO    = 0;

  // solution field bounds
  localparam int SOL_DEST_HI = 22;
  localparam int SOL_DEST_LO = 19;
  localparam int SOL_TAG_HI  = 18;
  localparam int SOL_TAG_LO  = 16;
  localparam int SOL_DATA_HI = 15;
  localparam int SOL_DATA_LO = 0;

  // Opcode bit 3 set means a memory op; the ALU never executes those.
  localparam int MEM_OP_BIT = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_SLT = 4'h5,
    OP_SLL = 4'h6,
    OP_SRL = 4'h7
  } opcode_e;

  // Packed layouts match the bit bounds above, MSB first.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
  } instr_t;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } solution_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_cdb_unit_if.sv
// Dispatch + CDB bundle of the ALU execution unit.
//   run, instruction_in : dispatch strobe and 43-bit instruction word
//   alu_ready           : unit can accept a dispatch this cycle
//   cdb_grant           : arbiter grants the CDB to this unit
//   store_cdb, solution : CDB request and 23-bit result word
//   drop_err            : sticky refused-dispatch flag
// master = reservation station / arbiter side, slave = the ALU unit.
interface alu_cdb_unit_if;
  import cdb_pkg::*;

  logic               run;
  logic [INSTR_W-1:0] instruction_in;
  logic               alu_ready;
  logic               cdb_grant;
  logic               store_cdb;
  logic [SOL_W-1:0]   solution;
  logic               drop_err;

  modport master (
    output run, instruction_in, cdb_grant,
    input  alu_ready, store_cdb, solution, drop_err
  );

  modport slave (
    input  run, instruction_in, cdb_grant,
    output alu_ready, store_cdb, solution, drop_err
  );

endinterface

// File: rtl/result_fifo.sv
// Synchronous result FIFO between ALU execution and CDB arbitration.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, push_data : write an entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry (valid when !empty)
//   empty, full, count : occupancy status
// Pointers wrap naturally; the extra count bit tells full from empty.
// A push into an empty FIFO becomes the head on that edge, with no
// same-cycle bypass.
module result_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count do, and
  // the top masks the head while empty, so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cdb_unit.sv
// ALU execution unit feeding the common data bus.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : dispatch from the reservation station (run,
//                  instruction_in, alu_ready) and CDB request towards the
//                  arbiter (store_cdb, solution, cdb_grant), plus drop_err.
// One op is in flight at a time: IDLE latches the operands, EXEC counts the
// op latency down and pushes {dest, tag, data} into the result FIFO, whose
// head is offered on the CDB until granted.
module alu_cdb_unit
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic           clock,
  input  logic           reset,
  alu_cdb_unit_if.slave  bus
);

  localparam int CNT_W  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

  alu_state_e        state;
  alu_state_e        next_state;
  instr_t            instr;
  logic [TAG_W-1:0]  tag_q;
  logic [REG_W-1:0]  dest_q;
  logic [OPC_W-1:0]  op_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] alu_result;
  logic              ready;
  logic              accept;
  logic              refuse;
  logic              exec_done;
  logic              drop_err_q;

  solution_t         push_entry;
  logic [SOL_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_pop;

  assign instr = instr_t'(bus.instruction_in);

  // Combinational so a dispatch can never be accepted into a full FIFO.
  assign ready         = (state == S_IDLE) && (fifo_count < DEPTH_C);
  assign bus.alu_ready = ready;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    refuse     = 1'b0;
    exec_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.run) begin
          if (ready && !instr.opcode[MEM_OP_BIT]) begin
            accept     = 1'b1;
            next_state = S_EXEC;
          end else begin
            refuse = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (bus.run) refuse = 1'b1;
        if (cnt == '0) begin
          exec_done  = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand latch, latency counter and sticky refusal flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_q      <= '0;
      dest_q     <= '0;
      op_q       <= '0;
      b_q        <= '0;
      c_q        <= '0;
      cnt        <= '0;
      drop_err_q <= 1'b0;
    end else begin
      if (accept) begin
        tag_q  <= instr.tag;
        dest_q <= instr.dest;
        op_q   <= instr.opcode;
        b_q    <= instr.b;
        c_q    <= instr.c;
        cnt    <= (instr.opcode == OP_MUL) ? MUL_LOAD : '0;
      end else if (state == S_EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (refuse) drop_err_q <= 1'b1;
    end
  end

  assign bus.drop_err = drop_err_q;

  // Results wrap modulo 2^16; shifts use only the low four bits of C.
  always_comb begin
    alu_result = '0;
    case (op_q)
      OP_ADD: alu_result = b_q + c_q;
      OP_SUB: alu_result = b_q - c_q;
      OP_MUL: alu_result = b_q * c_q;
      OP_AND: alu_result = b_q & c_q;
      OP_OR:  alu_result = b_q | c_q;
      OP_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(b_q) < $signed(c_q))};
      OP_SLL: alu_result = b_q << c_q[3:0];
      OP_SRL: alu_result = b_q >> c_q[3:0];
      default: alu_result = '0;
    endcase
  end

  assign push_entry = '{dest: dest_q, tag: tag_q, data: alu_result};
  assign fifo_pop   = !fifo_empty && bus.cdb_grant;

  result_fifo #(
    .WIDTH (SOL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (exec_done && !fifo_full),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign bus.store_cdb = !fifo_empty;
  assign bus.solution  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Self-checking bench for alu_cdb_unit: directed timing cases followed by
// randomized traffic. Expected CDB words are queued at dispatch and a
// monitor compares them in order whenever the unit presents a result.
module tb_alu_cdb_unit;
  import cdb_pkg::*;

  logic clock;
  logic reset;
  alu_cdb_unit_if bus();

  alu_cdb_unit #(.FIFO_DEPTH(4), .MUL_LATENCY(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [SOL_W-1:0] exp_q[$];
  int grant_mode = 0;   // 0 low, 1 high, 2 random

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference ALU from the opcode definitions, plain integer arithmetic.
  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] b, input logic [15:0] c);
    longint r;
    int sbv, scv, sh;
    sh  = int'(c) % 16;
    sbv = (int'(b) >= 32768) ? int'(b) - 65536 : int'(b);
    scv = (int'(c) >= 32768) ? int'(c) - 65536 : int'(c);
    case (op)
      4'd0: r = longint'(b) + longint'(c);
      4'd1: r = longint'(b) - longint'(c) + 65536;
      4'd2: r = longint'(b) * longint'(c);
      4'd3: r = longint'(b & c);
      4'd4: r = longint'(b | c);
      4'd5: r = (sbv < scv) ? 1 : 0;
      4'd6: r = longint'(b) * (longint'(1) << sh);
      4'd7: r = longint'(b) / (longint'(1) << sh);
      default: r = 0;
    endcase
    return 16'(r % 65536);
  endfunction

  function automatic logic [15:0] rand16();
    logic [15:0] corners [5];
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  // Grant driver: the only writer of cdb_grant, updates 2 time units after
  // each rising edge so mode changes made at +1 take effect the same cycle.
  initial begin
    bus.cdb_grant = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (grant_mode)
        0: bus.cdb_grant = 1'b0;
        1: bus.cdb_grant = 1'b1;
        default: bus.cdb_grant = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every presented result must match the oldest expectation;
  // it is retired only when granted.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && bus.store_cdb) begin
        check("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          if (bus.cdb_grant) begin
            check("cdb_pop", 32'(bus.solution), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end else begin
            check("cdb_hold", 32'(bus.solution), 32'(exp_q[0]));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d expected results pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Called at posedge+1. Waits (bounded) for alu_ready, dispatches one op
  // on the next edge and returns at that edge +1.
  task automatic dispatch(input logic [3:0] op, input logic [15:0] b, input logic [15:0] c,
                          input logic [2:0] tag, input logic [3:0] dest, input logic [15:0] exp);
    int waited = 0;
    while (!bus.alu_ready && waited < 64) begin
      @(posedge clock); #1;
      waited++;
    end
    if (!bus.alu_ready) begin
      check("ready_wait", 32'(bus.alu_ready), 32'd1);
      return;
    end
    bus.instruction_in = {tag, op, dest, b, c};
    bus.run = 1'b1;
    exp_q.push_back({dest, tag, exp});
    @(posedge clock); #1;
    bus.run = 1'b0;
    check("accept_busy", 32'(bus.alu_ready), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    bus.run = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] b, c;
    int waited;

    reset = 1'b1;
    bus.run = 1'b0;
    bus.instruction_in = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("rst_store_cdb", 32'(bus.store_cdb), 32'd0);
    check("rst_solution",  32'(bus.solution),  32'd0);
    check("rst_drop_err",  32'(bus.drop_err),  32'd0);

    // ADD with grant held high: result one edge after accept, one cycle long.
    grant_mode = 1;
    dispatch(4'h0, 16'h0005, 16'h0003, 3'd2, 4'd4, 16'h0008);
    check("add_no_bypass", 32'(bus.store_cdb), 32'd0);
    @(posedge clock); #1;
    check("add_store",    32'(bus.store_cdb), 32'd1);
    check("add_solution", 32'(bus.solution),  32'h220008);
    check("add_ready",    32'(bus.alu_ready), 32'd1);
    @(posedge clock); #1;
    check("add_one_cycle", 32'(bus.store_cdb), 32'd0);

    dispatch(4'h1, 16'h0000, 16'h0001, 3'd3, 4'd1, 16'hFFFF);
    repeat (2) @(posedge clock); #1;
    dispatch(4'h5, 16'hFFFF, 16'h0001, 3'd4, 4'd2, 16'h0001);
    repeat (2) @(posedge clock); #1;
    dispatch(4'h6, 16'h0001, 16'h001F, 3'd5, 4'd3, 16'h8000);
    repeat (2) @(posedge clock); #1;

    // MUL: busy for three cycles, pushed on the third edge after accept.
    dispatch(4'h2, 16'h0100, 16'h0100, 3'd6, 4'd7, 16'h0000);
    @(posedge clock); #1;
    check("mul_busy1", 32'(bus.alu_ready), 32'd0);
    @(posedge clock); #1;
    check("mul_busy2",  32'(bus.alu_ready), 32'd0);
    check("mul_early",  32'(bus.store_cdb), 32'd0);
    @(posedge clock); #1;
    check("mul_store",  32'(bus.store_cdb), 32'd1);
    check("mul_ready",  32'(bus.alu_ready), 32'd1);
    repeat (2) @(posedge clock); #1;

    // Memory opcode is refused.
    check("pre_mem_drop_err", 32'(bus.drop_err), 32'd0);
    bus.instruction_in = {3'd1, 4'b1000, 4'd1, 16'h1234, 16'h0001};
    bus.run = 1'b1;
    @(posedge clock); #1;
    bus.run = 1'b0;
    check("mem_drop_err", 32'(bus.drop_err),  32'd1);
    check("mem_ready",    32'(bus.alu_ready), 32'd1);
    repeat (3) begin
      @(posedge clock); #1;
      check("mem_no_result", 32'(bus.store_cdb), 32'd0);
    end

    // Fill the FIFO with the grant low, overflow attempt, then drain.
    do_reset();
    check("reset_clears_drop", 32'(bus.drop_err), 32'd0);
    grant_mode = 0;
    for (int i = 0; i < 4; i++) begin
      b = 16'(i + 1);
      c = 16'(16 * i);
      dispatch(4'h0, b, c, 3'(i), 4'(8 + i), ref_alu(4'h0, b, c));
      @(posedge clock); #1;
    end
    check("full_not_ready", 32'(bus.alu_ready), 32'd0);
    check("full_store",     32'(bus.store_cdb), 32'd1);
    check("full_no_drop",   32'(bus.drop_err),  32'd0);
    bus.instruction_in = {3'd7, 4'h0, 4'd15, 16'h00AA, 16'h0055};
    bus.run = 1'b1;
    @(posedge clock); #1;
    bus.run = 1'b0;
    check("overflow_drop", 32'(bus.drop_err),  32'd1);
    check("overflow_busy", 32'(bus.alu_ready), 32'd0);
    grant_mode = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("drain_store", 32'(bus.store_cdb), 32'd1);
    end
    @(negedge clock);
    check("drain_empty", 32'(bus.store_cdb), 32'd0);
    check("drain_all",   32'(exp_q.size()),  32'd0);

    // Reset during MUL execute with two results queued.
    @(posedge clock); #1;
    grant_mode = 0;
    dispatch(4'h3, 16'hF0F0, 16'h0FF0, 3'd1, 4'd1, ref_alu(4'h3, 16'hF0F0, 16'h0FF0));
    @(posedge clock); #1;
    dispatch(4'h4, 16'hF000, 16'h000F, 3'd2, 4'd2, ref_alu(4'h4, 16'hF000, 16'h000F));
    @(posedge clock); #1;
    check("queued_store", 32'(bus.store_cdb), 32'd1);
    dispatch(4'h2, 16'h1234, 16'h0002, 3'd3, 4'd3, ref_alu(4'h2, 16'h1234, 16'h0002));
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("midrst_store",    32'(bus.store_cdb), 32'd0);
    check("midrst_solution", 32'(bus.solution),  32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    grant_mode = 1;
    check("midrst_drop_err", 32'(bus.drop_err),  32'd0);
    check("midrst_ready",    32'(bus.alu_ready), 32'd1);
    repeat (6) begin
      @(negedge clock);
      check("midrst_no_stale", 32'(bus.store_cdb), 32'd0);
    end

    // Randomized traffic with a random grant.
    @(posedge clock); #1;
    grant_mode = 2;
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 7));
      b  = rand16();
      c  = rand16();
      dispatch(op, b, c, 3'($urandom), 4'($urandom), ref_alu(op, b, c));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
    grant_mode = 1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clock); #1;
      waited++;
    end
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
